mem_stage: RTL and testbench

//   MEM pipeline stage plus MEM/WB pipeline register of the 5-stage MIPS core.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_stage_if.sv | 16 +
 rtl/mem_stage_align.sv | 46 ++++
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: access sizes, FSM states, bus and MEM/WB payloads.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned RD_W   = 5;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [BE_W-1:0] BE_WORD = 4'hF;

    typedef enum logic {
        IDLE,
        ACCESS
    } mem_state_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } dmem_req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
        logic              mem_to_reg;
        logic              reg_write;
        logic [RD_W-1:0]   rd;
    } wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Ready-handshaked data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if;
    import mem_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, be, input ready, rdata);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata);

endinterface

// File: rtl/mem_stage_align.sv
// Sub-word lane logic: byte enables, store replication, load extract/extend, misalign detect.
// Present only when MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [BE_W-1:0]   be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_ext_o,
    output logic              misalign_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o        = BE_WORD;
        wdata_o     = store_data_i;
        rdata_ext_o = rdata_i;
        misalign_o  = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                be_o        = BE_W'(4'b0001 << addr_lo_i);
                wdata_o     = {4{store_data_i[7:0]}};
                rdata_ext_o = unsigned_i ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SIZE_HALF: begin
                be_o        = BE_W'(4'b0011 << {addr_lo_i[1], 1'b0});
                wdata_o     = {2{store_data_i[15:0]}};
                rdata_ext_o = unsigned_i ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
                misalign_o  = addr_lo_i[0];
            end
            default: misalign_o = (addr_lo_i != 2'b00);
        endcase
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// MEM stage + MEM/WB register: issues loads/stores on the dmem bus and stalls until ready.
// Sub-word (byte/half) access is enabled by defining MEM_SUBWORD_EN.
module mem_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    output logic              mem_stall,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [RD_W-1:0]   wb_rd,
    output logic [RD_W-1:0]   mem_fwd_rd,
    output logic              mem_fwd_en,
    output logic [DATA_W-1:0] mem_fwd_data
`ifdef MEM_SUBWORD_EN
   ,output logic              mem_misalign
`endif
);

    mem_state_t        state_q, state_d;
    dmem_req_t         dreq_q, dreq_d;
    wb_t               wb_q, wb_d;
    logic              misalign_q, misalign_d;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              al_misalign;
    logic              mem_op;
    logic              bus_op;
    logic              rd_nz;

`ifdef MEM_SUBWORD_EN
    mem_align u_align (
        .addr_lo_i    (ex_alu_result[1:0]),
        .size_i       (ex_size),
        .unsigned_i   (ex_unsigned),
        .store_data_i (ex_store_data),
        .rdata_i      (dmem.rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_ext_o  (al_rdata),
        .misalign_o   (al_misalign)
    );
    assign mem_misalign = misalign_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{ex_size, ex_unsigned};
    assign al_be       = BE_WORD;
    assign al_wdata    = ex_store_data;
    assign al_rdata    = dmem.rdata;
    assign al_misalign = 1'b0;
`endif

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
    assign bus_op = mem_op & ~al_misalign;
    assign rd_nz  = (ex_rd != '0);

    // State register and registered bus / MEM/WB payloads
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dreq_q     <= '0;
            wb_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dreq_q     <= dreq_d;
            wb_q       <= wb_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus_op) state_d = ACCESS;
            ACCESS:  if (dmem.ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: stall, next bus request, next MEM/WB contents (bubble unless something retires)
    always_comb begin
        dreq_d        = dreq_q;
        wb_d          = wb_q;
        wb_d.valid    = 1'b0;
        wb_d.reg_write = 1'b0;
        misalign_d    = 1'b0;
        mem_stall     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_op) begin
                    mem_stall    = 1'b1;
                    dreq_d.req   = 1'b1;
                    dreq_d.we    = ex_mem_write;
                    dreq_d.addr  = {ex_alu_result[ADDR_W-1:2], 2'b00};
                    dreq_d.wdata = al_wdata;
                    dreq_d.be    = al_be;
                end else begin
                    dreq_d.req      = 1'b0;
                    wb_d.valid      = ex_valid;
                    wb_d.alu_result = ex_alu_result;
                    wb_d.rd         = ex_rd;
                    wb_d.mem_to_reg = ex_mem_to_reg;
                    wb_d.reg_write  = ex_valid & ex_reg_write & ~mem_op & rd_nz;
                    misalign_d      = mem_op & al_misalign;
                end
            end
            ACCESS: begin
                mem_stall = ~dmem.ready;
                if (dmem.ready) begin
                    dreq_d.req      = 1'b0;
                    wb_d.valid      = 1'b1;
                    wb_d.alu_result = ex_alu_result;
                    wb_d.rd         = ex_rd;
                    wb_d.mem_to_reg = ex_mem_to_reg;
                    wb_d.reg_write  = ex_reg_write & ~dreq_q.we & rd_nz;
                    if (!dreq_q.we) wb_d.read_data = al_rdata;
                end
            end
            default: ;
        endcase
    end

    assign dmem.req   = dreq_q.req;
    assign dmem.we    = dreq_q.we;
    assign dmem.addr  = dreq_q.addr;
    assign dmem.wdata = dreq_q.wdata;
    assign dmem.be    = dreq_q.be;

    assign wb_valid      = wb_q.valid;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_read_data  = wb_q.read_data;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_rd         = wb_q.rd;

    // Forward tap never offers load data: loads are excluded from mem_fwd_en
    assign mem_fwd_rd   = ex_rd;
    assign mem_fwd_en   = ex_valid & ex_reg_write & ~ex_mem_read & rd_nz;
    assign mem_fwd_data = ex_alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB entries queued at issue, checked on wb_valid.
module tb_mem_stage;

`ifdef MEM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [4:0]  mem_fwd_rd;
    logic        mem_fwd_en;
    logic [31:0] mem_fwd_data;
`ifdef MEM_SUBWORD_EN
    logic        mem_misalign;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .mem_stall     (mem_stall),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_en    (mem_fwd_en),
        .mem_fwd_data  (mem_fwd_data)
`ifdef MEM_SUBWORD_EN
       ,.mem_misalign  (mem_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mis_f(input logic mr, input logic mw, input logic [1:0] size, input logic [1:0] a);
        if (!SUBWORD || !(mr | mw)) return 1'b0;
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] a);
        if (!SUBWORD) return 4'hF;
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] sd);
        if (!SUBWORD) return sd;
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic uns, input logic [1:0] a);
        logic [31:0] s;
        s = rdata >> (32'(a) * 8);
        if (!SUBWORD) return rdata;
        case (size)
            2'b00:   return uns ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            2'b01: begin
                s = a[1] ? {16'b0, rdata[31:16]} : {16'b0, rdata[15:0]};
                return uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            end
            default: return rdata;
        endcase
    endfunction

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
    endtask

    // One EX/MEM instruction, held while stalled; memory answers after 'waits' wait states.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic m2r,
                         input logic [1:0] size, input logic uns, input int waits,
                         input logic [31:0] rdata);
        logic mis;
        logic bus;
        exp_t e;
        mis = mis_f(mr, mw, size, alu[1:0]);
        bus = (mr | mw) & ~mis;
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
        ex_size = size; ex_unsigned = uns;
        e.alu = alu; e.rd = rd; e.m2r = m2r;
        e.rw = rw & ~mw & (rd != 5'd0) & ~mis;
        e.chk_rdata = bus & mr;
        e.rdata = load_f(rdata, size, uns, alu[1:0]);
        sb.push_back(e);
        #1;
        check_eq("stall_issue", 32'(mem_stall), 32'(bus));
        check_eq("fwd_en", 32'(mem_fwd_en), 32'(rw & ~mr & (rd != 5'd0)));
        check_eq("fwd_data", mem_fwd_data, alu);
        @(posedge clk); #1;
        if (bus) begin
            for (int w = 0; w <= waits; w++) begin
                check_eq("req_high", 32'(dmem_bus.req), 32'd1);
                if (w == 0) begin
                    check_eq("bus_we", 32'(dmem_bus.we), 32'(mw));
                    check_eq("bus_addr", dmem_bus.addr, {alu[31:2], 2'b00});
                    check_eq("bus_be", 32'(dmem_bus.be), 32'(be_f(size, alu[1:0])));
                    if (mw) check_eq("bus_wdata", dmem_bus.wdata, wdata_f(size, sd));
                end
                dmem_bus.ready = (w == waits);
                dmem_bus.rdata = (w == waits) ? rdata : $urandom;
                #1;
                check_eq("stall_access", 32'(mem_stall), 32'(w != waits));
                @(posedge clk); #1;
            end
            dmem_bus.ready = 1'b0;
            check_eq("req_drop", 32'(dmem_bus.req), 32'd0);
        end else begin
            check_eq("no_req", 32'(dmem_bus.req), 32'd0);
        end
`ifdef MEM_SUBWORD_EN
        check_eq("misalign", 32'(mem_misalign), 32'(mis));
`endif
        idle_inputs();
    endtask

    // Scoreboard monitor: registered outputs sampled on the falling edge
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wb_alu", wb_alu_result, mon_e.alu);
                check_eq("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                check_eq("wb_reg_write", 32'(wb_reg_write), 32'(mon_e.rw));
                check_eq("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(mon_e.m2r));
                if (mon_e.chk_rdata) check_eq("wb_read_data", wb_read_data, mon_e.rdata);
            end
        end else begin
            check_eq("wb_rw_bubble", 32'(wb_reg_write), 32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_size = 2'b10; ex_unsigned = 1'b0;
        idle_inputs();
        dmem_bus.ready = 1'b0;
        dmem_bus.rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", 32'(dmem_bus.req), 32'd0);
        check_eq("rst_we", 32'(dmem_bus.we), 32'd0);
        check_eq("rst_addr", dmem_bus.addr, 32'd0);
        check_eq("rst_wdata", dmem_bus.wdata, 32'd0);
        check_eq("rst_be", 32'(dmem_bus.be), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_alu", wb_alu_result, 32'd0);
        check_eq("rst_wb_rdata", wb_read_data, 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU op, load with 3 wait states, store with none
        issue(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        issue(32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 3, 32'hDEAD_BEEF);
        issue(32'h0000_0204, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        // rd==0 never writes; back-to-back load then store; then ALU op
        issue(32'h0000_0042, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        issue(32'h0000_0300, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1, 32'h1357_9BDF);
        issue(32'h0000_0400, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 32'h0BAD_F00D);
        issue(32'h0000_0404, 32'h1122_3344, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2, 32'h0);
        issue(32'hFFFF_FFF0, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);
        // Byte loads at 0x103 (word access with low bits ignored unless sub-word build)
        issue(32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 32'h80FF_FFFF);
        issue(32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1, 32'h80FF_FFFF);
`ifdef MEM_SUBWORD_EN
        issue(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 0, 32'h0);
        issue(32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 32'h8001_0000);
        issue(32'h0000_0102, 32'h0000_ABCD, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 0, 32'h0);
        issue(32'h0000_0101, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 0, 32'h0);
`endif

        // dmem_ready while IDLE is ignored
        @(negedge clk);
        dmem_bus.ready = 1'b1;
        dmem_bus.rdata = 32'h5555_AAAA;
        #1;
        check_eq("idle_ready_stall", 32'(mem_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle_ready_req", 32'(dmem_bus.req), 32'd0);
        dmem_bus.ready = 1'b0;

        // Reset in the middle of an access abandons it
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0500; ex_rd = 5'd10;
        ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1; ex_size = 2'b10;
        @(posedge clk); #1;
        check_eq("rst_mid_req_before", 32'(dmem_bus.req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        check_eq("rst_mid_req", 32'(dmem_bus.req), 32'd0);
        check_eq("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        dmem_bus.ready = 1'b1;
        dmem_bus.rdata = 32'h7777_7777;
        #1;
        check_eq("rst_mid_stall", 32'(mem_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        dmem_bus.ready = 1'b0;
        check_eq("rst_mid_req_after", 32'(dmem_bus.req), 32'd0);
        issue(32'h0000_0ABC, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
